// File: rtl/keypad_barcode_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package   : sale_terminal_pkg
// Purpose   : Shared constants, key map, and the entry FSM state type for the
//             SaleTerminal push-button receive path.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package sale_terminal_pkg;

  localparam int NUM_DIGITS              = 4;
  localparam int DIGIT_W                 = 4;
  localparam int ENTRY_W                 = NUM_DIGITS * DIGIT_W;
  localparam int COUNT_W                 = 3;
  localparam int NUM_KEYS                = 4;
  localparam int NUM_SW                  = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 5;

  // KEY index assignment
  localparam int KEY_COMMIT = 0;
  localparam int KEY_DIGIT1 = 3;
  localparam int KEY_DIGIT2 = 2;
  localparam int KEY_DIGIT3 = 1;

  // SW index assignment
  localparam int SW_COMMIT_MODE = 0;  // 1: barcode commit, 0: interactive select
  localparam int SW_CLEAR       = 2;  // synchronous buffer clear

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } entry_state_t;

  // Digit value for a single digit-key press vector (KEY[3:1]).
  // The caller guarantees at most one bit is set.
  function automatic logic [DIGIT_W-1:0] key_to_digit(input logic [3:1] keys);
    logic [DIGIT_W-1:0] d;
    d = '0;
    if (keys[KEY_DIGIT1])      d = DIGIT_W'(1);
    else if (keys[KEY_DIGIT2]) d = DIGIT_W'(2);
    else if (keys[KEY_DIGIT3]) d = DIGIT_W'(3);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_barcode_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : keypad_barcode_decoder_if
// Purpose   : Bundles the board-side pins (KEY, SW) and the decoded outputs
//             presented to the terminal controller.
// Modports  : master - drives KEY/SW, observes decoded outputs
//             slave  - the decoder: samples KEY/SW, drives decoded outputs
// Revision  : 1.0 - initial release
// ============================================================================
interface keypad_barcode_decoder_if;
  import sale_terminal_pkg::*;

  logic [NUM_KEYS-1:0] KEY;           // raw buttons, active low
  logic [NUM_SW-1:0]   SW;            // raw slide switches
  logic [NUM_KEYS-1:0] key_press;     // one-cycle debounced press events
  logic [COUNT_W-1:0]  digit_count;   // digits currently buffered
  logic [ENTRY_W-1:0]  entry_digits;  // live buffer, newest digit in [3:0]
  logic [ENTRY_W-1:0]  barcode;       // last committed barcode
  logic                barcode_valid; // pulse when barcode updates
  logic                item_select;   // pulse on interactive select
  logic                entry_error;   // pulse on rejected commit / ambiguous press

  modport master (
    output KEY, SW,
    input  key_press, digit_count, entry_digits, barcode,
           barcode_valid, item_select, entry_error
  );

  modport slave (
    input  KEY, SW,
    output key_press, digit_count, entry_digits, barcode,
           barcode_valid, item_select, entry_error
  );

endinterface
`default_nettype wire

// File: rtl/keypad_barcode_decoder_debouncer.sv
`default_nettype none
// ============================================================================
// Module    : key_debouncer
// Purpose   : 2-FF synchroniser, stability counter and press-edge detector for
//             one active-low push button.
// Ports     : clk    - system clock
//             rst    - asynchronous active-high reset
//             key_n  - raw active-low button
//             press  - registered one-cycle pulse on a debounced press
// Revision  : 1.0 - initial release
// ============================================================================
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_meta;
  logic             sync;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the released level so reset release never looks
  // like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sync      <= sync_meta;
    end
  end

  // The counter tracks how long sync has disagreed with deb; any agreement
  // (a bounce back) restarts it. On the flip, a press is reported only when
  // deb was high, i.e. the transition is 1 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb   <= sync;
        cnt   <= '0;
        press <= deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_barcode_decoder.sv
`default_nettype none
// ============================================================================
// Module    : keypad_barcode_decoder
// Purpose   : Debounces KEY[3:0], synchronises SW[2:0], assembles digit keys
//             into a barcode and issues commit / select / error pulses.
// Ports     : CLOCK_50 - system clock
//             RESET    - asynchronous active-high reset
//             bus      - keypad_barcode_decoder_if.slave (KEY, SW in;
//                        key_press, digit_count, entry_digits, barcode,
//                        barcode_valid, item_select, entry_error out)
// Revision  : 1.0 - initial release
// ============================================================================
module keypad_barcode_decoder
  import sale_terminal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  keypad_barcode_decoder_if.slave  bus
);

  logic [NUM_KEYS-1:0] press_evt;
  logic [NUM_SW-1:0]   sw_meta;
  logic [NUM_SW-1:0]   sw_s;

  entry_state_t        state;
  entry_state_t        state_next;
  logic [ENTRY_W-1:0]  entry_buf,   entry_buf_next;
  logic [COUNT_W-1:0]  digit_cnt,   digit_cnt_next;
  logic [ENTRY_W-1:0]  barcode_reg, barcode_next;
  logic                valid_reg,   valid_next;
  logic                select_reg,  select_next;
  logic                error_reg,   error_next;

  // --------------------------------------------------------------------------
  // Per-key debouncers
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debouncer (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (bus.KEY[i]),
        .press (press_evt[i])
      );
    end
  endgenerate

  // Switches are levels, so a plain synchroniser is enough.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= bus.SW;
      sw_s    <= sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Press decode
  // --------------------------------------------------------------------------
  logic [3:1] digit_keys;
  logic       commit;
  logic       commit_mode;
  logic       clear;
  logic       multi_digit;
  logic       accept_digit;

  assign digit_keys  = press_evt[3:1];
  assign commit      = press_evt[KEY_COMMIT];
  assign commit_mode = sw_s[SW_COMMIT_MODE];
  assign clear       = sw_s[SW_CLEAR];
  assign multi_digit = (digit_keys[3] & digit_keys[2]) |
                       (digit_keys[3] & digit_keys[1]) |
                       (digit_keys[2] & digit_keys[1]);
  // KEY[0] wins over any simultaneous digit; FULL silently drops digits.
  assign accept_digit = (|digit_keys) & ~multi_digit & ~commit & ~clear &
                        (state != FULL);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (commit) begin
      if (commit_mode) state_next = IDLE;
    end else if (accept_digit) begin
      state_next = (digit_cnt == COUNT_W'(NUM_DIGITS - 1)) ? FULL : ENTRY;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    entry_buf_next = entry_buf;
    digit_cnt_next = digit_cnt;
    barcode_next   = barcode_reg;
    valid_next     = 1'b0;
    select_next    = 1'b0;
    error_next     = 1'b0;

    // Interactive select does not depend on the entry state or the clear.
    if (commit && !commit_mode) select_next = 1'b1;

    if (clear) begin
      entry_buf_next = '0;
      digit_cnt_next = '0;
      // The FSM is pinned in IDLE, so a barcode commit here is incomplete.
      if (commit && commit_mode) error_next = 1'b1;
    end else if (commit && commit_mode) begin
      entry_buf_next = '0;
      digit_cnt_next = '0;
      if (state == FULL) begin
        barcode_next = entry_buf;
        valid_next   = 1'b1;
      end else begin
        error_next = 1'b1;
      end
    end else if (!commit && multi_digit) begin
      error_next = 1'b1;
    end else if (accept_digit) begin
      entry_buf_next = {entry_buf[ENTRY_W-DIGIT_W-1:0], key_to_digit(digit_keys)};
      digit_cnt_next = digit_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      entry_buf   <= '0;
      digit_cnt   <= '0;
      barcode_reg <= '0;
      valid_reg   <= 1'b0;
      select_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      entry_buf   <= entry_buf_next;
      digit_cnt   <= digit_cnt_next;
      barcode_reg <= barcode_next;
      valid_reg   <= valid_next;
      select_reg  <= select_next;
      error_reg   <= error_next;
    end
  end

  assign bus.key_press     = press_evt;
  assign bus.digit_count   = digit_cnt;
  assign bus.entry_digits  = entry_buf;
  assign bus.barcode       = barcode_reg;
  assign bus.barcode_valid = valid_reg;
  assign bus.item_select   = select_reg;
  assign bus.entry_error   = error_reg;

endmodule
`default_nettype wire

// File: tb/tb_keypad_barcode_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_keypad_barcode_decoder
// Purpose   : Directed and randomised stimulus for keypad_barcode_decoder,
//             compared every cycle against a queue-based reference model.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_keypad_barcode_decoder;

  localparam int DEB = 5;
  localparam int ND  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_barcode_decoder_if ifc ();

  keypad_barcode_decoder #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (ifc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raw samples are delayed two edges, a key level is
  // accepted after DEB+1 consecutive disagreeing edges, and the entry buffer
  // is a queue of digit values.
  // --------------------------------------------------------------------------
  logic [3:0] key_hist[$];
  logic [2:0] sw_hist[$];
  logic [3:0] m_level;
  int         m_run[4];
  logic [3:0] m_kp;
  int         m_buf[$];
  logic [15:0] m_bar;
  logic       m_valid, m_sel, m_err;
  logic [3:0] m_s;
  logic [2:0] m_sws;
  int         m_nd;

  function automatic logic [15:0] pack(input int q[$]);
    logic [15:0] v;
    v = 16'h0;
    foreach (q[k]) v = (v << 4) | 16'(q[k]);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      key_hist.delete();
      sw_hist.delete();
      m_level = 4'hF;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_kp    = 4'h0;
      m_buf.delete();
      m_bar   = 16'h0;
      m_valid = 1'b0;
      m_sel   = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_s   = (key_hist.size() >= 2) ? key_hist[key_hist.size()-2] : 4'hF;
      m_sws = (sw_hist.size()  >= 2) ? sw_hist[sw_hist.size()-2]   : 3'b000;

      // Controller reacts to the press events reported last cycle.
      m_valid = 1'b0;
      m_sel   = 1'b0;
      m_err   = 1'b0;
      m_nd    = int'(m_kp[3]) + int'(m_kp[2]) + int'(m_kp[1]);
      if (m_sws[2]) begin
        if (m_kp[0]) begin
          if (m_sws[0]) m_err = 1'b1;
          else          m_sel = 1'b1;
        end
        m_buf.delete();
      end else if (m_kp[0]) begin
        if (m_sws[0]) begin
          if (m_buf.size() == ND) begin
            m_bar   = pack(m_buf);
            m_valid = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_buf.delete();
        end else begin
          m_sel = 1'b1;
        end
      end else if (m_nd >= 2) begin
        m_err = 1'b1;
      end else if (m_nd == 1 && m_buf.size() < ND) begin
        for (int i = 1; i < 4; i++) if (m_kp[i]) m_buf.push_back(4 - i);
      end

      // Debounced press events.
      for (int i = 0; i < 4; i++) begin
        m_kp[i] = 1'b0;
        if (m_s[i] !== m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_level[i] = m_s[i];
            m_run[i]   = 0;
            m_kp[i]    = ~m_s[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end

      key_hist.push_back(ifc.KEY);
      if (key_hist.size() > 2) void'(key_hist.pop_front());
      sw_hist.push_back(ifc.SW);
      if (sw_hist.size() > 2) void'(sw_hist.pop_front());
    end
  end

  // Cycle-by-cycle comparison and pulse counters.
  int n_valid = 0, n_sel = 0, n_err = 0;
  int n_kp[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!rst) begin
      check("key_press",     32'(ifc.key_press),     32'(m_kp));
      check("digit_count",   32'(ifc.digit_count),   32'(m_buf.size()));
      check("entry_digits",  32'(ifc.entry_digits),  32'(pack(m_buf)));
      check("barcode",       32'(ifc.barcode),       32'(m_bar));
      check("barcode_valid", 32'(ifc.barcode_valid), 32'(m_valid));
      check("item_select",   32'(ifc.item_select),   32'(m_sel));
      check("entry_error",   32'(ifc.entry_error),   32'(m_err));
      n_valid += int'(ifc.barcode_valid);
      n_sel   += int'(ifc.item_select);
      n_err   += int'(ifc.entry_error);
      for (int i = 0; i < 4; i++) n_kp[i] += int'(ifc.key_press[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge clk);
    ifc.KEY = ~mask;
    repeat (hold) @(negedge clk);
    ifc.KEY = 4'hF;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic set_sw(input logic [2:0] v);
    @(negedge clk);
    ifc.SW = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_key_press"},     32'(ifc.key_press),     32'h0);
    check({pfx, "_digit_count"},   32'(ifc.digit_count),   32'h0);
    check({pfx, "_entry_digits"},  32'(ifc.entry_digits),  32'h0);
    check({pfx, "_barcode"},       32'(ifc.barcode),       32'h0);
    check({pfx, "_barcode_valid"}, 32'(ifc.barcode_valid), 32'h0);
    check({pfx, "_item_select"},   32'(ifc.item_select),   32'h0);
    check({pfx, "_entry_error"},   32'(ifc.entry_error),   32'h0);
  endtask

  int base, first_seen, r, hold;
  logic [3:0] rmask;

  initial begin
    ifc.KEY = 4'hF;
    ifc.SW  = 3'b000;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Barcode 1-2-1-3 then commit.
    set_sw(3'b001);
    press(4'b1000, 10);
    press(4'b0100, 10);
    press(4'b1000, 10);
    press(4'b0010, 10);
    check("dir_entry_1213", 32'(ifc.entry_digits), 32'h1213);
    check("dir_count_full", 32'(ifc.digit_count),  32'd4);
    press(4'b0001, 10);
    check("dir_barcode",    32'(ifc.barcode),      32'h1213);
    check("dir_valid_once", 32'(n_valid),          32'd1);
    check("dir_count_zero", 32'(ifc.digit_count),  32'd0);

    // Interactive select keeps the buffer.
    set_sw(3'b000);
    base = n_kp[1];
    press(4'b0010, 10);
    check("sel_kp1_once",   32'(n_kp[1] - base),   32'd1);
    check("sel_entry_3",    32'(ifc.entry_digits), 32'h0003);
    press(4'b0001, 10);
    check("sel_pulse_once", 32'(n_sel),            32'd1);
    check("sel_entry_kept", 32'(ifc.entry_digits), 32'h0003);
    check("sel_no_valid",   32'(n_valid),          32'd1);

    // Short entry rejected on commit.
    set_sw(3'b100);
    set_sw(3'b000);
    check("clr_count",      32'(ifc.digit_count),  32'd0);
    press(4'b0010, 10);
    press(4'b0100, 10);
    set_sw(3'b001);
    base = n_err;
    press(4'b0001, 10);
    check("short_err_once", 32'(n_err - base),     32'd1);
    check("short_count",    32'(ifc.digit_count),  32'd0);
    check("short_barcode",  32'(ifc.barcode),      32'h1213);

    // Bounce rejection, then exact press latency.
    base = n_kp[2];
    @(negedge clk); ifc.KEY = 4'b1011;
    repeat (3) @(negedge clk); ifc.KEY = 4'hF;
    repeat (2) @(negedge clk); ifc.KEY = 4'b1011;
    repeat (3) @(negedge clk); ifc.KEY = 4'hF;
    repeat (10) @(negedge clk);
    check("bounce_no_press", 32'(n_kp[2] - base), 32'd0);
    ifc.KEY    = 4'b1011;
    first_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ifc.key_press[2] && first_seen == 0) first_seen = n;
    end
    ifc.KEY = 4'hF;
    repeat (DEB + 6) @(negedge clk);
    check("press_latency",   32'(first_seen),     32'd8);
    check("press_once",      32'(n_kp[2] - base), 32'd1);

    // Overflow and ambiguous press.
    set_sw(3'b100);
    set_sw(3'b000);
    press(4'b1000, 10);
    press(4'b1000, 10);
    press(4'b0100, 10);
    press(4'b0100, 10);
    press(4'b0010, 10);
    check("full_entry",  32'(ifc.entry_digits), 32'h1122);
    check("full_count",  32'(ifc.digit_count),  32'd4);
    set_sw(3'b100);
    set_sw(3'b000);
    press(4'b1000, 10);
    base = n_err;
    press(4'b1100, 10);
    check("multi_err",   32'(n_err - base),     32'd1);
    check("multi_entry", 32'(ifc.entry_digits), 32'h0001);

    // Reset in the middle of entry with KEY[3] held.
    press(4'b0100, 10);
    @(negedge clk); ifc.KEY = 4'b0111;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    base = n_kp[3];
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    ifc.KEY = 4'hF;
    repeat (DEB + 8) @(negedge clk);
    check("rst_no_press", 32'(n_kp[3] - base),   32'd0);
    press(4'b1000, 10);
    check("rst_repress",  32'(n_kp[3] - base),   32'd1);
    check("rst_entry",    32'(ifc.entry_digits), 32'h0001);

    // Randomised traffic against the model.
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 19));
      @(negedge clk);
      if (r < 3) ifc.SW = {($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rmask = 4'b0001 << $urandom_range(1, 3);
        6:                rmask = 4'b0001;
        7:                rmask = (4'b0001 << $urandom_range(1, 3)) | (4'b0001 << $urandom_range(1, 3));
        8:                rmask = (4'b0001 << $urandom_range(1, 3)) | 4'b0001;
        default:          rmask = 4'($urandom_range(1, 15));
      endcase
      hold = int'($urandom_range(1, 12));
      ifc.KEY = ~rmask;
      repeat (hold) @(negedge clk);
      ifc.KEY = 4'hF;
      repeat ($urandom_range(DEB + 2, DEB + 10)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
